// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clock cycles within one UART bit and flags the
// last cycle of each bit so the FSM can advance on bit boundaries.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running within a bit; held at zero while the FSM is outside the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the synchronous FIFO one byte at a time and serialises each byte
// as a UART 8N1 frame, LSB first. The next byte is fetched only after the
// current stop bit has finished.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_en,
  input  logic                      fifo_empty,
  input  logic [UART_DATA_BITS-1:0] fifo_data,
  output logic                      fifo_rd,
  output logic                      tx,
  output logic                      busy,
  output logic                      tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state;
  tx_state_t                 state_next;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [2:0]                bit_idx;
  logic                      bit_tick;
  logic                      baud_clear;

  // The bit timer only runs during START/DATA/STOP so every frame starts
  // with a full-length start bit.
  assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the FIFO flag is only consulted while idle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tx_en && !fifo_empty) state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (bit_tick) state_next = DATA;
      DATA:    if (bit_tick && (bit_idx == LAST_BIT)) state_next = STOP;
      STOP:    if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift register and bit index: load the popped byte, then shift right
  // at the end of every data bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        LOAD: begin
          shift_reg <= fifo_data;
          bit_idx   <= '0;
        end
        DATA: begin
          if (bit_tick) begin
            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            bit_idx   <= bit_idx + 3'd1;
          end
        end
        default: begin
          shift_reg <= shift_reg;
          bit_idx   <= bit_idx;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only, so none depends on an input.
  always_comb begin
    tx      = UART_IDLE_LEVEL;
    fifo_rd = 1'b0;
    busy    = (state != IDLE);
    tx_done = 1'b0;
    case (state)
      FETCH:   fifo_rd = 1'b1;
      START:   tx      = 1'b0;
      DATA:    tx      = shift_reg[0];
      STOP:    tx_done = bit_tick;
      default: tx      = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (4 and 2 clocks per bit),
// each fed by a small FIFO model whose empty flag lags by two cycles.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Cycle counter used to measure latencies and frame pitch.
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: CLKS_PER_BIT = 4 ----------------
  logic       tx_en_a = 1'b0, fifo_empty_a = 1'b1, fifo_rd_a, tx_a, busy_a, tx_done_a;
  logic [7:0] fifo_data_a = 8'h00;
  logic [7:0] mem_a [8];
  logic [2:0] wr_a = 3'd0, rd_a = 3'd0;
  int         cnt_a = 0, pops_a = 0, bad_pops_a = 0, dones_a = 0;
  logic       empty_pipe_a = 1'b1, push_a = 1'b0;
  logic [7:0] push_data_a = 8'h00;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .tx_en(tx_en_a), .fifo_empty(fifo_empty_a),
    .fifo_data(fifo_data_a), .fifo_rd(fifo_rd_a), .tx(tx_a), .busy(busy_a),
    .tx_done(tx_done_a)
  );

  // FIFO model A: data valid the cycle after a pop, empty flag two stages late.
  always @(posedge clk) begin
    if (push_a && cnt_a < 8) begin
      mem_a[wr_a] <= push_data_a;
      wr_a        <= wr_a + 3'd1;
    end
    if (fifo_rd_a) begin
      pops_a <= pops_a + 1;
      if (fifo_empty_a || cnt_a == 0) bad_pops_a <= bad_pops_a + 1;
      else begin
        fifo_data_a <= mem_a[rd_a];
        rd_a        <= rd_a + 3'd1;
      end
    end
    cnt_a <= cnt_a + ((push_a && cnt_a < 8) ? 1 : 0)
                   - ((fifo_rd_a && !fifo_empty_a && cnt_a > 0) ? 1 : 0);
    empty_pipe_a <= (cnt_a == 0);
    fifo_empty_a <= empty_pipe_a;
    if (tx_done_a) dones_a <= dones_a + 1;
  end

  // ---------------- instance B: CLKS_PER_BIT = 2 ----------------
  logic       tx_en_b = 1'b0, fifo_empty_b = 1'b1, fifo_rd_b, tx_b, busy_b, tx_done_b;
  logic [7:0] fifo_data_b = 8'h00;
  logic [7:0] mem_b [8];
  logic [2:0] wr_b = 3'd0, rd_b = 3'd0;
  int         cnt_b = 0, pops_b = 0, bad_pops_b = 0;
  logic       empty_pipe_b = 1'b1, push_b = 1'b0;
  logic [7:0] push_data_b = 8'h00;

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst(rst), .tx_en(tx_en_b), .fifo_empty(fifo_empty_b),
    .fifo_data(fifo_data_b), .fifo_rd(fifo_rd_b), .tx(tx_b), .busy(busy_b),
    .tx_done(tx_done_b)
  );

  // FIFO model B, same behaviour as model A.
  always @(posedge clk) begin
    if (push_b && cnt_b < 8) begin
      mem_b[wr_b] <= push_data_b;
      wr_b        <= wr_b + 3'd1;
    end
    if (fifo_rd_b) begin
      pops_b <= pops_b + 1;
      if (fifo_empty_b || cnt_b == 0) bad_pops_b <= bad_pops_b + 1;
      else begin
        fifo_data_b <= mem_b[rd_b];
        rd_b        <= rd_b + 3'd1;
      end
    end
    cnt_b <= cnt_b + ((push_b && cnt_b < 8) ? 1 : 0)
                   - ((fifo_rd_b && !fifo_empty_b && cnt_b > 0) ? 1 : 0);
    empty_pipe_b <= (cnt_b == 0);
    fifo_empty_b <= empty_pipe_b;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_a_byte(input logic [7:0] b);
    push_data_a = b;
    push_a      = 1'b1;
    @(negedge clk);
    push_a      = 1'b0;
  endtask

  task automatic push_b_byte(input logic [7:0] b);
    push_data_b = b;
    push_b      = 1'b1;
    @(negedge clk);
    push_b      = 1'b0;
  endtask

  // Returns at the first negedge where tx is low (frame cycle 1).
  task automatic wait_tx_fall(input bit use_b, input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((use_b ? tx_b : tx_a) == 1'b0) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // Samples tx and tx_done for len cycles starting at the current negedge.
  task automatic record_frame(input bit use_b, input int len, output logic [39:0] txs, output logic [39:0] dn);
    txs = '0;
    dn  = '0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      txs[i] = use_b ? tx_b : tx_a;
      dn[i]  = use_b ? tx_done_b : tx_done_a;
    end
  endtask

  function automatic logic [39:0] exp_frame(input logic [7:0] b, input int cpb);
    logic [9:0]  bits;
    logic [39:0] r;
    bits = {1'b1, b, 1'b0};
    r    = '0;
    for (int i = 0; i < 10 * cpb; i++) r[i] = bits[i / cpb];
    return r;
  endfunction

  function automatic logic [39:0] exp_done(input int len);
    logic [39:0] d;
    d          = '0;
    d[len - 1] = 1'b1;
    return d;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int tx_low, rd_hits, busy_hits;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (tx_done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_b: got %b expected 1", tx_b); end
    rst     = 1'b1;
    tx_en_a = 1'b1;
    tx_low = 0; rd_hits = 0; busy_hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) tx_low++;
      if (fifo_rd_a !== 1'b0) rd_hits++;
      if (busy_a !== 1'b0) busy_hits++;
    end
    checks++; if (tx_low !== 0) begin errors++; $display("[TB] FAIL idle_tx: got %0d low cycles expected 0", tx_low); end
    checks++; if (rd_hits !== 0) begin errors++; $display("[TB] FAIL idle_rd: got %0d pops expected 0", rd_hits); end
    checks++; if (busy_hits !== 0) begin errors++; $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", busy_hits); end
  endtask

  task automatic test_single_byte();
    int e_at, t_at;
    bit e_ok, ok;
    logic [39:0] txs, dn;
    e_at = -1; e_ok = 1'b0;
    push_a_byte(8'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_empty_a == 1'b0) begin e_at = cyc; e_ok = 1'b1; break; end
    end
    wait_tx_fall(1'b0, 20, t_at, ok);
    checks++; if (!(e_ok && ok)) begin errors++; $display("[TB] FAIL single_start: got %b expected 1", e_ok && ok); end
    checks++; if (t_at - e_at !== 3) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 3", t_at - e_at); end
    record_frame(1'b0, 40, txs, dn);
    checks++; if (txs !== exp_frame(8'hA5, 4)) begin errors++; $display("[TB] FAIL single_bits: got %h expected %h", txs, exp_frame(8'hA5, 4)); end
    checks++; if (dn !== exp_done(40)) begin errors++; $display("[TB] FAIL single_done: got %h expected %h", dn, exp_done(40)); end
    repeat (10) @(negedge clk);
    checks++; if (pops_a !== 1) begin errors++; $display("[TB] FAIL single_pops: got %0d expected 1", pops_a); end
  endtask

  task automatic test_back_to_back();
    int pops0, at, prev;
    bit ok;
    logic [39:0] txs, dn;
    tx_en_a = 1'b0;
    for (int k = 0; k < 8; k++) push_a_byte(8'(k));
    checks++; if (cnt_a !== 8) begin errors++; $display("[TB] FAIL burst_fill: got %0d expected 8", cnt_a); end
    repeat (3) @(negedge clk);
    pops0   = pops_a;
    prev    = -1;
    tx_en_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_tx_fall(1'b0, 60, at, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL burst_start%0d: got 0 expected 1", k); break; end
      record_frame(1'b0, 40, txs, dn);
      checks++; if (txs !== exp_frame(8'(k), 4)) begin errors++; $display("[TB] FAIL burst_bits%0d: got %h expected %h", k, txs, exp_frame(8'(k), 4)); end
      checks++; if (dn !== exp_done(40)) begin errors++; $display("[TB] FAIL burst_done%0d: got %h expected %h", k, dn, exp_done(40)); end
      if (k > 0) begin
        checks++; if (at - prev !== 43) begin errors++; $display("[TB] FAIL burst_pitch%0d: got %0d expected 43", k, at - prev); end
      end
      prev = at;
    end
    repeat (60) @(negedge clk);
    checks++; if (pops_a - pops0 !== 8) begin errors++; $display("[TB] FAIL burst_pops: got %0d expected 8", pops_a - pops0); end
    checks++; if (cnt_a !== 0) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 0", cnt_a); end
    checks++; if (bad_pops_a !== 0) begin errors++; $display("[TB] FAIL burst_empty_pop: got %0d expected 0", bad_pops_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL burst_idle: got %b expected 0", busy_a); end
  endtask

  task automatic test_tx_en_drop();
    int at, c, busy_hits, rd_hits;
    bit ok;
    logic [39:0] txs, dn;
    tx_en_a = 1'b0;
    push_a_byte(8'h11);
    push_a_byte(8'h22);
    push_a_byte(8'h33);
    repeat (3) @(negedge clk);
    tx_en_a = 1'b1;
    wait_tx_fall(1'b0, 20, at, ok);
    record_frame(1'b0, 40, txs, dn);
    checks++; if (txs !== exp_frame(8'h11, 4)) begin errors++; $display("[TB] FAIL drop_f1: got %h expected %h", txs, exp_frame(8'h11, 4)); end
    wait_tx_fall(1'b0, 20, at, ok);
    tx_en_a = 1'b0;
    record_frame(1'b0, 40, txs, dn);
    checks++; if (txs !== exp_frame(8'h22, 4)) begin errors++; $display("[TB] FAIL drop_f2: got %h expected %h", txs, exp_frame(8'h22, 4)); end
    checks++; if (dn !== exp_done(40)) begin errors++; $display("[TB] FAIL drop_f2_done: got %h expected %h", dn, exp_done(40)); end
    busy_hits = 0; rd_hits = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_a) busy_hits++;
      if (fifo_rd_a) rd_hits++;
    end
    checks++; if (busy_hits !== 0 || rd_hits !== 0) begin errors++; $display("[TB] FAIL drop_idle: got busy %0d rd %0d expected 0 0", busy_hits, rd_hits); end
    checks++; if (cnt_a !== 1) begin errors++; $display("[TB] FAIL drop_left: got %0d expected 1", cnt_a); end
    tx_en_a = 1'b1;
    c       = cyc;
    wait_tx_fall(1'b0, 20, at, ok);
    checks++; if (!ok || at - c !== 3) begin errors++; $display("[TB] FAIL drop_relatency: got %0d expected 3", at - c); end
    record_frame(1'b0, 40, txs, dn);
    checks++; if (txs !== exp_frame(8'h33, 4)) begin errors++; $display("[TB] FAIL drop_f3: got %h expected %h", txs, exp_frame(8'h33, 4)); end
  endtask

  task automatic test_reset_mid_frame();
    int at, dones0;
    bit ok;
    logic [39:0] txs, dn;
    push_a_byte(8'h44);
    push_a_byte(8'h55);
    wait_tx_fall(1'b0, 20, at, ok);
    dones0 = dones_a;
    repeat (21) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 1", busy_a); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_tx: got %b expected 1", tx_a); end
    checks++; if (busy_a !== 1'b0 || fifo_rd_a !== 1'b0 || tx_done_a !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_idle: got busy %b rd %b done %b expected 0 0 0", busy_a, fifo_rd_a, tx_done_a);
    end
    rst = 1'b1;
    wait_tx_fall(1'b0, 20, at, ok);
    record_frame(1'b0, 40, txs, dn);
    checks++; if (txs !== exp_frame(8'h55, 4)) begin errors++; $display("[TB] FAIL mid_next: got %h expected %h", txs, exp_frame(8'h55, 4)); end
    @(negedge clk);
    checks++; if (dones_a - dones0 !== 1) begin errors++; $display("[TB] FAIL mid_dones: got %0d expected 1", dones_a - dones0); end
  endtask

  task automatic test_cpb2();
    int at1, at2, pops0;
    bit ok1, ok2;
    logic [39:0] txs, dn;
    push_b_byte(8'hFF);
    push_b_byte(8'h00);
    repeat (3) @(negedge clk);
    pops0   = pops_b;
    tx_en_b = 1'b1;
    wait_tx_fall(1'b1, 20, at1, ok1);
    record_frame(1'b1, 20, txs, dn);
    checks++; if (txs !== exp_frame(8'hFF, 2)) begin errors++; $display("[TB] FAIL cpb2_ff: got %h expected %h", txs, exp_frame(8'hFF, 2)); end
    checks++; if (dn !== exp_done(20)) begin errors++; $display("[TB] FAIL cpb2_ff_done: got %h expected %h", dn, exp_done(20)); end
    checks++; if (pops_b - pops0 !== 1) begin errors++; $display("[TB] FAIL cpb2_early_pop: got %0d expected 1", pops_b - pops0); end
    wait_tx_fall(1'b1, 20, at2, ok2);
    checks++; if (!(ok1 && ok2) || at2 - at1 !== 23) begin errors++; $display("[TB] FAIL cpb2_pitch: got %0d expected 23", at2 - at1); end
    record_frame(1'b1, 20, txs, dn);
    checks++; if (txs !== exp_frame(8'h00, 2)) begin errors++; $display("[TB] FAIL cpb2_00: got %h expected %h", txs, exp_frame(8'h00, 2)); end
    checks++; if (dn !== exp_done(20)) begin errors++; $display("[TB] FAIL cpb2_00_done: got %h expected %h", dn, exp_done(20)); end
    checks++; if (pops_b - pops0 !== 2 || bad_pops_b !== 0) begin errors++; $display("[TB] FAIL cpb2_pops: got %0d/%0d expected 2/0", pops_b - pops0, bad_pops_b); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid_frame();
    test_cpb2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
